multicycle_cpu: RTL and testbench

Parametrised multi-cycle MIPS-subset processor. It is the successor to the single-cycle core. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB states, so one ALU and registered intermediates (IR, A, B, ALUOut, MDR) serve every instruction. Instruction and data memory depths are parameters. The block adds `beq`, `j`, `halt`, a retire pulse and a debug register port. Instruction memory is loaded through the same initialize port as before.

---
 rtl/multicycle_cpu.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_cpu
// Description : Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT)
//               sharing one ALU through registered IR/A/B/ALUOut/MDR.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cpu #(
  parameter int          IMEM_AW  = 8,
  parameter int          DMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        initialize,
  input  logic [31:0] instruction_initialize_data,
  input  logic [31:0] instruction_initialize_address,
  input  logic [4:0]  dbg_reg_sel,
  output logic [31:0] dbg_reg_data,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_halt  = 6'h3F;

  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_mdr;
  logic        r_retire;
  logic        r_halted;

  logic [31:0] r_rf   [0:31];
  logic [31:0] r_imem [0:(1<<IMEM_AW)-1];
  logic [31:0] r_dmem [0:(1<<DMEM_AW)-1];

  logic [IMEM_AW-1:0] w_imem_idx;
  logic [IMEM_AW-1:0] w_init_idx;
  logic [DMEM_AW-1:0] w_dmem_idx;
  logic [31:0]        w_fetch_word;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_se;
  logic [25:0] w_target;

  logic w_is_rtype;
  logic w_funct_ok;
  logic w_is_alu_r;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_addi;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_j;
  logic w_is_halt;
  logic w_needs_exec;

  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  logic        w_alu_zero;
  logic        w_branch_taken;
  logic [31:0] w_branch_target;
  logic [4:0]  w_wb_dst;
  logic [31:0] w_wb_data;
  logic        w_unused;

  assign w_imem_idx = r_pc[IMEM_AW+1:2];
  assign w_init_idx = instruction_initialize_address[IMEM_AW+1:2];
  assign w_dmem_idx = r_alu_out[DMEM_AW+1:2];

  // Load mode presents all-ones to the fetch path; the frozen FSM never latches it.
  assign w_fetch_word = initialize ? 32'hFFFF_FFFF : r_imem[w_imem_idx];

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_imm_se = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_target = r_ir[25:0];

  assign w_is_rtype = (w_op == c_op_rtype);
  assign w_funct_ok = (w_funct == c_fn_add) || (w_funct == c_fn_sub) ||
                      (w_funct == c_fn_and) || (w_funct == c_fn_or)  ||
                      (w_funct == c_fn_slt);
  assign w_is_alu_r = w_is_rtype && w_funct_ok;
  assign w_is_lw    = (w_op == c_op_lw);
  assign w_is_sw    = (w_op == c_op_sw);
  assign w_is_addi  = (w_op == c_op_addi);
  assign w_is_beq   = (w_op == c_op_beq);
  assign w_is_bne   = (w_op == c_op_bne);
  assign w_is_j     = (w_op == c_op_j);
  assign w_is_halt  = (w_op == c_op_halt);

  assign w_needs_exec = w_is_alu_r || w_is_lw || w_is_sw || w_is_addi ||
                        w_is_beq || w_is_bne;

  // Branches compare A against B through the shared ALU's subtract path.
  assign w_alu_b = (w_is_rtype || w_is_beq || w_is_bne) ? r_b : w_imm_se;

  always_comb begin
    w_alu_res = r_a + w_alu_b;
    if (w_is_beq || w_is_bne) begin
      w_alu_res = r_a - w_alu_b;
    end else if (w_is_rtype) begin
      case (w_funct)
        c_fn_sub: w_alu_res = r_a - w_alu_b;
        c_fn_and: w_alu_res = r_a & w_alu_b;
        c_fn_or:  w_alu_res = r_a | w_alu_b;
        c_fn_slt: w_alu_res = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
        default:  w_alu_res = r_a + w_alu_b;
      endcase
    end
  end

  assign w_alu_zero      = (w_alu_res == 32'd0);
  assign w_branch_taken  = (w_is_beq && w_alu_zero) || (w_is_bne && !w_alu_zero);
  assign w_branch_target = r_pc + {w_imm_se[29:0], 2'b00};

  assign w_wb_dst  = w_is_rtype ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu_out;

  assign w_unused = ^{instruction_initialize_address[31:IMEM_AW+2],
                      instruction_initialize_address[1:0], r_ir[10:6]};

  always_ff @(posedge clk) begin
    if (initialize) begin
      r_imem[w_init_idx] <= instruction_initialize_data;
    end
  end

  // Stores land only on the MEM-state edge; reset forces FETCH so none can leak.
  always_ff @(posedge clk) begin
    if (!initialize && (r_state == S_MEM) && w_is_sw) begin
      r_dmem[w_dmem_idx] <= r_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
      r_mdr     <= 32'd0;
      r_retire  <= 1'b0;
      r_halted  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (initialize) begin
      r_retire <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ir    <= w_fetch_word;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a <= r_rf[w_rs];
          r_b <= r_rf[w_rt];
          if (w_is_j) begin
            r_pc     <= {r_pc[31:28], w_target, 2'b00};
            r_state  <= S_FETCH;
            r_retire <= 1'b1;
          end else if (w_is_halt) begin
            r_state  <= S_HALT;
            r_retire <= 1'b1;
            r_halted <= 1'b1;
          end else if (w_needs_exec) begin
            r_state <= S_EXEC;
          end else begin
            r_state  <= S_FETCH;
            r_retire <= 1'b1;
          end
        end
        S_EXEC: begin
          r_alu_out <= w_alu_res;
          if (w_is_beq || w_is_bne) begin
            if (w_branch_taken) begin
              r_pc <= w_branch_target;
            end
            r_state  <= S_FETCH;
            r_retire <= 1'b1;
          end else if (w_is_lw || w_is_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_is_lw) begin
            r_mdr   <= r_dmem[w_dmem_idx];
            r_state <= S_WB;
          end else begin
            r_state  <= S_FETCH;
            r_retire <= 1'b1;
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) begin
            r_rf[w_wb_dst] <= w_wb_data;
          end
          r_state  <= S_FETCH;
          r_retire <= 1'b1;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? 32'd0 : r_rf[dbg_reg_sel];
  assign pc           = r_pc;
  assign retire       = r_retire;
  assign halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_cpu
// Description : Directed self-checking bench for multicycle_cpu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data;
  logic [31:0] pc;
  logic        retire;
  logic        halted;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_ret;
  int          ret_cyc [0:15];
  logic [31:0] ret_pc  [0:15];

  localparam logic [31:0] c_halt = 32'hFC00_0000;

  multicycle_cpu #(
    .IMEM_AW  (8),
    .DMEM_AW  (8),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk                            (clk),
    .rst                            (rst),
    .initialize                     (initialize),
    .instruction_initialize_data    (instruction_initialize_data),
    .instruction_initialize_address (instruction_initialize_address),
    .dbg_reg_sel                    (dbg_reg_sel),
    .dbg_reg_data                   (dbg_reg_data),
    .pc                             (pc),
    .retire                         (retire),
    .halted                         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    initialize = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    initialize                     = 1'b1;
    instruction_initialize_address = addr;
    instruction_initialize_data    = data;
    tick();
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_reg_sel = r;
    #1;
    check(tag, dbg_reg_data, exp);
  endtask

  // Release load mode and clock until halted, logging each retire's cycle and pc.
  task automatic run(input string tag, input int max_cyc);
    initialize = 1'b0;
    n_ret      = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (retire) begin
        if (n_ret < 16) begin
          ret_cyc[n_ret] = c;
          ret_pc[n_ret]  = pc;
        end
        n_ret++;
      end
      if (halted) break;
    end
    check({tag, "_halt_reached"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    rst                            = 1'b1;
    initialize                     = 1'b0;
    instruction_initialize_data    = 32'd0;
    instruction_initialize_address = 32'd0;
    dbg_reg_sel                    = 5'd0;

    // Reset state
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    chk_reg("rst_r3", 5'd3, 32'd0);

    // Arithmetic program
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, f_r(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, f_r(5'd2, 5'd1, 5'd4, 6'h22));
    put(32'h10, f_r(5'd2, 5'd1, 5'd5, 6'h2A));
    put(32'h14, c_halt);
    check("load_pc_held", pc, 32'h0);
    check("load_no_retire", {31'd0, retire}, 32'd0);
    run("arith", 60);
    check("arith_retires", 32'(n_ret), 32'd6);
    check("arith_first_retire", 32'(ret_cyc[0]), 32'd4);
    check("arith_halt_cycle", 32'(ret_cyc[5]), 32'd22);
    chk_reg("arith_r3", 5'd3, 32'd2);
    chk_reg("arith_r4", 5'd4, 32'hFFFF_FFF8);
    chk_reg("arith_r5", 5'd5, 32'd1);
    tick();
    tick();
    tick();
    check("halt_pc_frozen", pc, 32'h18);
    check("halt_no_retire", {31'd0, retire}, 32'd0);
    check("halt_sticky", {31'd0, halted}, 32'd1);

    // Store then loads, second one through the wrapped address
    do_reset();
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h08, f_i(6'h23, 5'd0, 5'd6, 16'd8));
    put(32'h0C, f_i(6'h23, 5'd0, 5'd7, 16'h0408));
    put(32'h10, c_halt);
    run("mem", 60);
    check("mem_retires", 32'(n_ret), 32'd5);
    check("lw1_cpi", 32'(ret_cyc[2] - ret_cyc[1]), 32'd5);
    check("lw2_cpi", 32'(ret_cyc[3] - ret_cyc[2]), 32'd5);
    chk_reg("mem_r6", 5'd6, 32'd5);
    chk_reg("mem_r7_wrap", 5'd7, 32'd5);

    // Taken beq over two addi's, then untaken bne
    do_reset();
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h04, 5'd1, 5'd1, 16'd2));
    put(32'h08, f_i(6'h08, 5'd0, 5'd8, 16'd1));
    put(32'h0C, f_i(6'h08, 5'd0, 5'd9, 16'd1));
    put(32'h10, f_i(6'h05, 5'd1, 5'd1, 16'd2));
    put(32'h14, f_i(6'h08, 5'd0, 5'd10, 16'd3));
    put(32'h18, c_halt);
    run("br", 60);
    check("br_pc_after_addi", ret_pc[0], 32'h04);
    check("beq_taken_pc", ret_pc[1], 32'h10);
    check("bne_fallthru_pc", ret_pc[2], 32'h14);
    check("beq_cpi", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
    check("bne_cpi", 32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
    chk_reg("br_skip_r8", 5'd8, 32'd0);
    chk_reg("br_skip_r9", 5'd9, 32'd0);
    chk_reg("br_r10", 5'd10, 32'd3);

    // Jump, then a write aimed at $0
    do_reset();
    put(32'h00, {6'h02, 26'h10});
    put(32'h40, f_i(6'h08, 5'd0, 5'd0, 16'd7));
    put(32'h44, c_halt);
    run("jmp", 40);
    check("j_cpi", 32'(ret_cyc[0]), 32'd2);
    check("j_target_pc", ret_pc[0], 32'h40);
    check("j_halt_pc", pc, 32'h48);
    chk_reg("r0_zero", 5'd0, 32'd0);

    // Reset while lw sits in MEM
    do_reset();
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h08, f_i(6'h23, 5'd0, 5'd6, 16'd8));
    put(32'h0C, c_halt);
    initialize = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    check("lw_mem_pc", pc, 32'h0C);
    rst = 1'b1;
    #1;
    check("abort_pc", pc, 32'h0);
    check("abort_retire", {31'd0, retire}, 32'd0);
    check("abort_halted", {31'd0, halted}, 32'd0);
    chk_reg("abort_r6", 5'd6, 32'd0);
    tick();
    rst = 1'b0;

    // Undefined opcode and unlisted R-type funct behave as NOPs
    do_reset();
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h3E, 5'd0, 5'd1, 16'd9));
    put(32'h08, f_r(5'd1, 5'd1, 5'd11, 6'h3F));
    put(32'h0C, c_halt);
    run("nop", 40);
    check("undef_op_cpi", 32'(ret_cyc[1] - ret_cyc[0]), 32'd2);
    check("bad_funct_cpi", 32'(ret_cyc[2] - ret_cyc[1]), 32'd2);
    chk_reg("nop_r1", 5'd1, 32'd5);
    chk_reg("nop_r11", 5'd11, 32'd0);

    // Load mode asserted mid-instruction freezes the core
    do_reset();
    put(32'h00, f_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, f_i(6'h08, 5'd1, 5'd2, 16'd1));
    put(32'h08, c_halt);
    initialize = 1'b0;
    tick();
    tick();
    tick();
    put(32'h80, 32'h1234_5678);
    put(32'h84, 32'h1234_5678);
    put(32'h88, 32'h1234_5678);
    check("freeze_pc", pc, 32'h04);
    check("freeze_no_retire", {31'd0, retire}, 32'd0);
    initialize = 1'b0;
    tick();
    check("resume_retire", {31'd0, retire}, 32'd1);
    run("resume", 40);
    chk_reg("resume_r1", 5'd1, 32'd5);
    chk_reg("resume_r2", 5'd2, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
